// File: rtl/simd_alu_pkg.sv
// Shared types for the SIMD saturating ALU: op encoding, FSM states, helpers.
// Build option: define SIMD_SAT_ALU_RED_EN to include the lane-reduction state.
package simd_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PADDSB = 2'b10,
    OP_RED    = 2'b11
  } op_e;

`ifdef SIMD_SAT_ALU_RED_EN
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RED_ACC = 2'b01,
    HOLD    = 2'b10
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b10
  } state_e;
`endif

  // True when v is a positive power of two; used for elaboration checks.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/simd_lane_add.sv
// One SIMD lane: LANE_W-bit adder with carry in/out and optional signed
// saturation. sat flags a signed overflow that was clamped (sat_en high only).
module simd_lane_add
  import simd_alu_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic signed [LANE_W-1:0] a,
  input  logic signed [LANE_W-1:0] b,
  input  logic                     cin,
  input  logic                     sat_en,
  output logic signed [LANE_W-1:0] sum,
  output logic                     cout,
  output logic                     sat
);

  logic [LANE_W:0]          full;
  logic signed [LANE_W-1:0] raw;
  logic                     ovf;

  // Clamp an overflowed lane to the most positive or most negative value.
  function automatic logic signed [LANE_W-1:0] sat_lane(
    input logic signed [LANE_W-1:0] v,
    input logic                     o,
    input logic                     neg
  );
    if (!o)
      return v;
    else if (neg)
      return {1'b1, {(LANE_W-1){1'b0}}};
    else
      return {1'b0, {(LANE_W-1){1'b1}}};
  endfunction

  // Raw add, signed overflow detect and optional clamp.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
    raw  = full[LANE_W-1:0];
    cout = full[LANE_W];
    ovf  = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
    sat  = sat_en & ovf;
    sum  = sat_en ? sat_lane(raw, ovf, a[LANE_W-1]) : raw;
  end

endmodule

// File: rtl/simd_sat_alu.sv
// SIMD saturating ALU: full-width saturating ADD/SUB, per-lane saturating
// PADDSB, and an optional multi-cycle lane reduction (RED).
// Build option: SIMD_SAT_ALU_RED_EN enables RED; without it op=11 acts as ADD.
module simd_sat_alu
  import simd_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ovfl
);

  localparam int LANES = WIDTH / LANE_W;

  if ((WIDTH % LANE_W) != 0) begin : g_chk_width
    $error("simd_sat_alu: WIDTH must be a multiple of LANE_W");
  end
  if (!is_pow2(LANES) || (LANES < 2)) begin : g_chk_lanes
    $error("simd_sat_alu: WIDTH/LANE_W must be a power of two >= 2");
  end

  state_e state, state_nx;
  op_e    op_in;
  logic   out_slot_free;
  logic   accept;
  logic   load_res;

  logic signed [WIDTH-1:0] res_data;
  logic                    res_ovfl;
  logic signed [WIDTH-1:0] fast_data;
  logic                    fast_ovfl;

  logic             is_sub;
  logic             sat_en;
  logic             chain_en;
  logic             word_ovf;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] lane_sum;
  logic [LANES-1:0] lane_cin;
  logic [LANES-1:0] lane_cout;
  logic [LANES-1:0] lane_sat;

  assign op_in         = op_e'(op);
  assign out_slot_free = ~out_valid | out_ready;
  assign in_ready      = (state == IDLE) & out_slot_free;
  assign accept        = in_valid & in_ready;

  // Saturate a full-width sum: a wrapped sign bit tells the true direction.
  function automatic logic signed [WIDTH-1:0] sat_word(
    input logic signed [WIDTH-1:0] v,
    input logic                    o
  );
    if (!o)
      return v;
    else if (v[WIDTH-1])
      return {1'b0, {(WIDTH-1){1'b1}}};
    else
      return {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  // Operand conditioning and carry-chain gating for the lane adders.
  always_comb begin
    is_sub = (op_in == OP_SUB);
    sat_en = (op_in == OP_PADDSB);
`ifdef SIMD_SAT_ALU_RED_EN
    chain_en = (op_in == OP_ADD) | (op_in == OP_SUB);
`else
    chain_en = (op_in != OP_PADDSB);
`endif
    b_opnd = is_sub ? ~b : b;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_cin0
      assign lane_cin[i] = is_sub;
    end else begin : g_cinn
      assign lane_cin[i] = chain_en & lane_cout[i-1];
    end

    simd_lane_add #(
      .LANE_W (LANE_W)
    ) u_lane (
      .a      (a[i*LANE_W +: LANE_W]),
      .b      (b_opnd[i*LANE_W +: LANE_W]),
      .cin    (lane_cin[i]),
      .sat_en (sat_en),
      .sum    (lane_sum[i*LANE_W +: LANE_W]),
      .cout   (lane_cout[i]),
      .sat    (lane_sat[i])
    );
  end

  // Single-cycle result: carry into the MSB is recovered from the sum bit,
  // so word overflow is that carry XOR the final carry-out.
  always_comb begin
    word_ovf = lane_cout[LANES-1] ^ (a[WIDTH-1] ^ b_opnd[WIDTH-1] ^ lane_sum[WIDTH-1]);
    if (sat_en) begin
      fast_data = lane_sum;
      fast_ovfl = |lane_sat;
    end else begin
      fast_data = sat_word(lane_sum, word_ovf);
      fast_ovfl = word_ovf;
    end
  end

`ifdef SIMD_SAT_ALU_RED_EN
  localparam int ACC_W = LANE_W + 1 + $clog2(LANES);
  localparam int IDX_W = $clog2(LANES) + 1;

  if (ACC_W > WIDTH) begin : g_chk_acc
    $error("simd_sat_alu: reduction accumulator wider than WIDTH");
  end

  logic [WIDTH-1:0]         a_red_p1;
  logic [WIDTH-1:0]         b_red_p1;
  logic signed [ACC_W-1:0]  acc_p1;
  logic [IDX_W-1:0]         idx_p1;
  logic [IDX_W-2:0]         lane_sel;
  logic signed [LANE_W-1:0] red_a_lane;
  logic signed [LANE_W-1:0] red_b_lane;
  logic signed [ACC_W-1:0]  pair_sum;
  logic signed [WIDTH-1:0]  acc_ext;
  logic                     red_done;
  logic                     red_start;
  logic                     red_step;

  // Select the current lane pair and sign-extend into the accumulator width.
  always_comb begin
    lane_sel   = idx_p1[IDX_W-2:0];
    red_a_lane = a_red_p1[lane_sel*LANE_W +: LANE_W];
    red_b_lane = b_red_p1[lane_sel*LANE_W +: LANE_W];
    pair_sum   = ACC_W'(red_a_lane) + ACC_W'(red_b_lane);
    acc_ext    = WIDTH'(acc_p1);
    red_done   = (idx_p1 == IDX_W'(LANES));
  end
`endif

  // Next-state and result-load decisions.
  always_comb begin
    state_nx = state;
    load_res = 1'b0;
    res_data = fast_data;
    res_ovfl = fast_ovfl;
`ifdef SIMD_SAT_ALU_RED_EN
    red_start = 1'b0;
    red_step  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef SIMD_SAT_ALU_RED_EN
          if (op_in == OP_RED) begin
            red_start = 1'b1;
            state_nx  = RED_ACC;
          end else begin
            load_res = 1'b1;
          end
`else
          load_res = 1'b1;
`endif
        end
      end
`ifdef SIMD_SAT_ALU_RED_EN
      RED_ACC: begin
        if (!red_done) begin
          red_step = 1'b1;
        end else begin
          res_data = acc_ext;
          res_ovfl = 1'b0;
          if (out_slot_free) begin
            load_res = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        res_data = acc_ext;
        res_ovfl = 1'b0;
        if (out_slot_free) begin
          load_res = 1'b1;
          state_nx = IDLE;
        end
      end
`else
      HOLD: begin
        state_nx = IDLE;
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output register; output holds until consumed or replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovfl      <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_res) begin
        out_valid <= 1'b1;
        out_data  <= res_data;
        ovfl      <= res_ovfl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SIMD_SAT_ALU_RED_EN
  // --- stage p1: operands captured at RED acceptance ---
  always_ff @(posedge clk) begin
    if (red_start) begin
      a_red_p1 <= a;
      b_red_p1 <= b;
    end
  end

  // Accumulate one lane pair per cycle, lane 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
      idx_p1 <= '0;
    end else if (red_start) begin
      acc_p1 <= '0;
      idx_p1 <= '0;
    end else if (red_step) begin
      acc_p1 <= acc_p1 + pair_sum;
      idx_p1 <= idx_p1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_sat_alu.sv
// Scoreboard bench for simd_sat_alu (WIDTH=16, LANE_W=4).
module tb_simd_sat_alu;
  import simd_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        ovfl;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sent   = 0;
  bit bp_en    = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic        ov;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  simd_sat_alu #(
    .WIDTH  (16),
    .LANE_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovfl      (ovfl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lane_val(input logic [15:0] x, input int i);
    logic [3:0] nib;
    nib = x[4*i +: 4];
    return (nib > 4'd7) ? int'(nib) - 16 : int'(nib);
  endfunction

  function automatic logic [16:0] sat16(input int r);
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  // Reference model: returns {ovfl, data}.
  function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int          sx;
    int          sy;
    int          s;
    logic [15:0] d;
    logic        ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    d  = '0;
    ov = 1'b0;
    case (o)
      2'b00: return sat16(sx + sy);
      2'b01: return sat16(sx - sy);
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          s = lane_val(x, i) + lane_val(y, i);
          if (s > 7) begin s = 7; ov = 1'b1; end
          else if (s < -8) begin s = -8; ov = 1'b1; end
          d[4*i +: 4] = s[3:0];
        end
        return {ov, d};
      end
      default: begin
`ifdef SIMD_SAT_ALU_RED_EN
        s = 0;
        for (int i = 0; i < 4; i++) s = s + lane_val(x, i) + lane_val(y, i);
        return {1'b0, s[15:0]};
`else
        return sat16(sx + sy);
`endif
      end
    endcase
  endfunction

  // Drive one transaction; returns at posedge+1 after acceptance.
  task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit push);
    int          n;
    logic [16:0] m;
    op = o; a = x; b = y; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1);
    if (in_ready && push) begin
      m = model(o, x, y);
      sb.push_back('{d: m[15:0], ov: m[16], id: n_sent});
      n_sent++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 0);
  endtask

  // Compare each delivered result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check($sformatf("out%0d_data", mon_e.id), out_data, mon_e.d);
        check($sformatf("out%0d_ovfl", mon_e.id), ovfl, mon_e.ov);
      end
    end
  end

  initial begin
    // Reset and idle state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovfl", ovfl, 0);
    check("rst_in_ready", in_ready, 1);

    // ADD positive overflow, 1-cycle latency
    send(OP_ADD, 16'h7000, 16'h1000, 1);
    check("add_lat_valid", out_valid, 1);
    check("add_sat_data", out_data, 16'h7FFF);
    check("add_no_bubble", in_ready, 1);

    // SUB cases, ADD negative overflow, carry across lanes
    send(OP_SUB, 16'h8000, 16'h0001, 1);
    send(OP_SUB, 16'h0005, 16'h0003, 1);
    send(OP_ADD, 16'h8000, 16'hFFFF, 1);
    send(OP_ADD, 16'h00F0, 16'h0010, 1);

    // PADDSB: mixed saturation, all-negative clamp, no inter-lane carry
    send(OP_PADDSB, 16'h7F81, 16'h1111, 1);
    check("paddsb_data", out_data, 16'h7092);
    send(OP_PADDSB, 16'h8888, 16'h8888, 1);
    send(OP_PADDSB, 16'h1234, 16'h1111, 1);
    send(OP_PADDSB, 16'h00F0, 16'h0010, 1);
    drain();

    // RED timing and values
    send(OP_RED, 16'h1234, 16'h1111, 1);
`ifdef SIMD_SAT_ALU_RED_EN
    for (int i = 0; i < 5; i++) begin
      check($sformatf("red_busy%0d", i), {in_ready, out_valid}, 2'b00);
      @(posedge clk);
      #1;
    end
    check("red_lat_valid", out_valid, 1);
    check("red_data", out_data, 16'h000E);
`else
    check("op11_lat_valid", out_valid, 1);
`endif
    send(OP_RED, 16'hFFFF, 16'h8888, 1);
    drain();

    // Back-pressure: result held, then same-edge handshake and accept
    out_ready = 1'b0;
    send(OP_ADD, 16'h0001, 16'h0002, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_data%0d", i), out_data, 16'h0003);
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    send(OP_SUB, 16'h0010, 16'h0001, 1);
    check("bp_next_data", out_data, 16'h000F);
    drain();

`ifdef SIMD_SAT_ALU_RED_EN
    // Reset during RED abandons the operation
    send(OP_RED, 16'h1234, 16'h1111, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_red_valid", out_valid, 0);
    check("rst_red_ready", in_ready, 1);
    check("rst_red_data", out_data, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_red_quiet%0d", i), out_valid, 0);
    end
`else
    send(OP_RED, 16'h0001, 16'h0002, 1);
    check("op11_as_add", out_data, 16'h0003);
    drain();
`endif

    // Random traffic under random back-pressure
    bp_en = 1'b1;
    fork
      begin
        while (bp_en) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 20; i++) begin
      send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1);
    end
    bp_en = 1'b0;
    repeat (3) @(posedge clk);
    out_ready = 1'b1;
    drain();

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
